pic24progmem_dp: RTL and testbench



---
 rtl/pic24progmem_pkg.sv | 27 ++
 rtl/pic24progmem_bank.sv | 47 ++++
 rtl/pic24progmem_dp.sv | 151 +++++++++++++++
 tb/tb_pic24progmem_dp.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pic24progmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pic24progmem_pkg
// Brief    : Shared types and helpers for the dual-port PIC24 program memory.
// Revision : 1.0 - initial release
// ============================================================================
package pic24progmem_pkg;

   localparam int NBYTES = 3;

   typedef enum logic [0:0] {
      INIT = 1'b0,
      IDLE = 1'b1
   } state_t;

   // Even parity: each bit makes its byte plus itself an even-weight 9-bit group.
   function automatic logic [NBYTES-1:0] byte_parity(input logic [8*NBYTES-1:0] word);
      logic [NBYTES-1:0] par;
      par = '0;
      for (int i = 0; i < NBYTES; i++) begin
         par[i] = ^word[8*i +: 8];
      end
      return par;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pic24progmem_bank.sv
`default_nettype none
// ============================================================================
// Module   : pic24progmem_bank
// Brief    : Raw true dual-port read-first array; A read-only, B byte-lane write.
// Revision : 1.0 - initial release
// ============================================================================
module pic24progmem_bank #(
   parameter int AW       = 10,
   parameter int NB_LANES = 3,
   parameter int LANE_W   = 8
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         i_a_re,
   input  logic [AW-1:0]                i_a_addr,
   output logic [NB_LANES*LANE_W-1:0]   o_a_rdata,
   input  logic                         i_b_re,
   input  logic [NB_LANES-1:0]          i_b_we,
   input  logic [AW-1:0]                i_b_addr,
   input  logic [NB_LANES*LANE_W-1:0]   i_b_wdata,
   output logic [NB_LANES*LANE_W-1:0]   o_b_rdata
);

   localparam int WIDTH = NB_LANES * LANE_W;
   localparam int DEPTH = 2 ** AW;

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Read registers only load on an accepted read so the last word is held.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         o_a_rdata <= '0;
         o_b_rdata <= '0;
      end else begin
         if (i_a_re) o_a_rdata <= r_mem[i_a_addr];
         if (i_b_re) o_b_rdata <= r_mem[i_b_addr];
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NB_LANES; i++) begin
         if (i_b_we[i]) r_mem[i_b_addr][i*LANE_W +: LANE_W] <= i_b_wdata[i*LANE_W +: LANE_W];
      end
   end

endmodule
`default_nettype wire

// File: rtl/pic24progmem_dp.sv
`default_nettype none
// ============================================================================
// Module   : pic24progmem_dp
// Brief    : Dual-port PIC24 program memory with fill engine; optional byte
//            parity via PIC24PROGMEM_PARITY_EN (needs DATAWIDTH = 8*NBYTES).
// Revision : 1.0 - initial release
// ============================================================================
module pic24progmem_dp
   import pic24progmem_pkg::*;
#(
   parameter int                   DATAWIDTH   = 8 * NBYTES,
   parameter int                   MEMSIZElog2 = 10,
   parameter logic [DATAWIDTH-1:0] FILL        = '0
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       init_req,
   output logic                       busy,
   input  logic                       f_req,
   input  logic [MEMSIZElog2-1:0]     f_addr,
   output logic [DATAWIDTH-1:0]       f_rdata,
   output logic                       f_valid,
   output logic                       f_perr,
   input  logic                       p_ce,
   input  logic                       p_we,
   input  logic [DATAWIDTH/8-1:0]     p_be,
   input  logic [MEMSIZElog2-1:0]     p_addr,
   input  logic [DATAWIDTH-1:0]       p_wdata,
   output logic [DATAWIDTH-1:0]       p_rdata,
   output logic                       p_rvalid
);

   localparam int NB_LANES = DATAWIDTH / 8;
`ifdef PIC24PROGMEM_PARITY_EN
   localparam int LANE_W   = 9;
`else
   localparam int LANE_W   = 8;
`endif
   localparam int ARR_W    = NB_LANES * LANE_W;

   state_t                 r_state;
   logic [MEMSIZElog2-1:0] r_cnt;
   logic                   r_busy;
   logic                   r_f_valid;
   logic                   r_p_rvalid;

   logic                   w_f_acc;
   logic                   w_p_rd;
   logic                   w_p_wr;
   logic [NB_LANES-1:0]    w_b_we;
   logic [MEMSIZElog2-1:0] w_b_addr;
   logic [DATAWIDTH-1:0]   w_b_data;
   logic [ARR_W-1:0]       w_b_wdata;
   logic [ARR_W-1:0]       w_a_rdata;
   logic [ARR_W-1:0]       w_b_rdata;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= INIT;
         r_cnt   <= '0;
         r_busy  <= 1'b1;
      end else begin
         case (r_state)
            INIT: begin
               if (&r_cnt) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_cnt   <= '0;
               end else begin
                  r_cnt   <= r_cnt + 1'b1;
               end
            end
            IDLE: begin
               if (init_req) begin
                  r_state <= INIT;
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
               end
            end
            default: begin
               r_state <= INIT;
               r_busy  <= 1'b1;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign w_f_acc = f_req & ~r_busy;
   assign w_p_rd  = p_ce & ~p_we & ~r_busy;
   assign w_p_wr  = p_ce &  p_we & ~r_busy;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_f_valid  <= 1'b0;
         r_p_rvalid <= 1'b0;
      end else begin
         r_f_valid  <= w_f_acc;
         r_p_rvalid <= w_p_rd;
      end
   end

   // The fill engine owns port B for the whole sweep.
   assign w_b_we   = r_busy ? {NB_LANES{1'b1}} : (w_p_wr ? p_be : '0);
   assign w_b_addr = r_busy ? r_cnt : p_addr;
   assign w_b_data = r_busy ? FILL  : p_wdata;

`ifdef PIC24PROGMEM_PARITY_EN
   logic [NB_LANES-1:0] w_wpar;
   logic [NB_LANES-1:0] w_perr_lane;

   assign w_wpar = byte_parity(w_b_data);

   for (genvar g = 0; g < NB_LANES; g++) begin : g_par_lane
      assign w_b_wdata[g*LANE_W +: LANE_W] = {w_wpar[g], w_b_data[g*8 +: 8]};
      assign f_rdata[g*8 +: 8]             = w_a_rdata[g*LANE_W +: 8];
      assign p_rdata[g*8 +: 8]             = w_b_rdata[g*LANE_W +: 8];
      assign w_perr_lane[g]                = ^w_a_rdata[g*LANE_W +: LANE_W];
   end

   assign f_perr = r_f_valid & (|w_perr_lane);
`else
   assign w_b_wdata = w_b_data;
   assign f_rdata   = w_a_rdata;
   assign p_rdata   = w_b_rdata;
   assign f_perr    = 1'b0;
`endif

   pic24progmem_bank #(
      .AW       (MEMSIZElog2),
      .NB_LANES (NB_LANES),
      .LANE_W   (LANE_W)
   ) u_bank (
      .clk       (clk),
      .rstn      (rstn),
      .i_a_re    (w_f_acc),
      .i_a_addr  (f_addr),
      .o_a_rdata (w_a_rdata),
      .i_b_re    (w_p_rd),
      .i_b_we    (w_b_we),
      .i_b_addr  (w_b_addr),
      .i_b_wdata (w_b_wdata),
      .o_b_rdata (w_b_rdata)
   );

   assign busy     = r_busy;
   assign f_valid  = r_f_valid;
   assign p_rvalid = r_p_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_pic24progmem_dp.sv
`default_nettype none
// ============================================================================
// Module   : tb_pic24progmem_dp
// Brief    : Self-checking bench for pic24progmem_dp against an array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pic24progmem_dp;

   localparam int          AW    = 4;
   localparam int          DEPTH = 16;
   localparam logic [23:0] FILLW = 24'hA5A5A5;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        init_req = 1'b0;
   logic        busy;
   logic        f_req = 1'b0;
   logic [3:0]  f_addr = '0;
   logic [23:0] f_rdata;
   logic        f_valid;
   logic        f_perr;
   logic        p_ce = 1'b0;
   logic        p_we = 1'b0;
   logic [2:0]  p_be = '0;
   logic [3:0]  p_addr = '0;
   logic [23:0] p_wdata = '0;
   logic [23:0] p_rdata;
   logic        p_rvalid;

   int          checks = 0;
   int          failures = 0;
   logic [23:0] mdl [DEPTH];
   logic [23:0] exp_f = '0;
   logic [23:0] exp_p = '0;

   always #5 clk = ~clk;

   pic24progmem_dp #(
      .DATAWIDTH   (24),
      .MEMSIZElog2 (AW),
      .FILL        (FILLW)
   ) u_dut (
      .clk      (clk),
      .rstn     (rstn),
      .init_req (init_req),
      .busy     (busy),
      .f_req    (f_req),
      .f_addr   (f_addr),
      .f_rdata  (f_rdata),
      .f_valid  (f_valid),
      .f_perr   (f_perr),
      .p_ce     (p_ce),
      .p_we     (p_we),
      .p_be     (p_be),
      .p_addr   (p_addr),
      .p_wdata  (p_wdata),
      .p_rdata  (p_rdata),
      .p_rvalid (p_rvalid)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [23:0] merge(input logic [23:0] old, input logic [23:0] wd,
                                         input logic [2:0] be);
      logic [23:0] res;
      res = old;
      for (int i = 0; i < 3; i++) if (be[i]) res[8*i +: 8] = wd[8*i +: 8];
      return res;
   endfunction

   task automatic idle_inputs();
      f_req = 1'b0; p_ce = 1'b0; p_we = 1'b0; p_be = '0; init_req = 1'b0;
   endtask

   task automatic fill_model();
      for (int a = 0; a < DEPTH; a++) mdl[a] = FILLW;
   endtask

   // One idle-state cycle: model the read-first array, advance, compare outputs.
   task automatic cyc(input string tag);
      logic ef, ep;
      ef = f_req;
      ep = p_ce & ~p_we;
      if (ef) exp_f = mdl[f_addr];
      if (ep) exp_p = mdl[p_addr];
      if (p_ce && p_we) mdl[p_addr] = merge(mdl[p_addr], p_wdata, p_be);
      tick();
      chk({tag, "_fvalid"}, f_valid, ef);
      chk({tag, "_frdata"}, f_rdata, exp_f);
      chk({tag, "_pvalid"}, p_rvalid, ep);
      chk({tag, "_prdata"}, p_rdata, exp_p);
`ifndef PIC24PROGMEM_PARITY_EN
      chk({tag, "_fperr"}, f_perr, 1'b0);
`endif
   endtask

   task automatic wait_sweep(input string tag);
      int n;
      n = 0;
      while (busy === 1'b1 && n < 64) begin
         tick();
         n++;
      end
      chk(tag, n, 16);
   endtask

   task automatic fetch_all(input string tag);
      for (int a = 0; a < DEPTH; a++) begin
         f_req = 1'b1; f_addr = 4'(a);
         cyc(tag);
      end
      idle_inputs();
   endtask

   initial begin
      int n;
      int pulses;

      // Reset state
      repeat (3) tick();
      chk("rst_busy", busy, 1'b1);
      chk("rst_fvalid", f_valid, 1'b0);
      chk("rst_pvalid", p_rvalid, 1'b0);
      chk("rst_frdata", f_rdata, 24'h0);
      chk("rst_prdata", p_rdata, 24'h0);
      chk("rst_fperr", f_perr, 1'b0);
      rstn = 1'b1;
      wait_sweep("reset_sweep_len");
      fill_model();
      fetch_all("fill_fetch");

      // Partial byte write
      p_ce = 1'b1; p_we = 1'b1; p_be = 3'b010; p_addr = 4'd5; p_wdata = 24'h123456;
      cyc("bytewr");
      idle_inputs();
      f_req = 1'b1; f_addr = 4'd5;
      cyc("bytewr_fetch");
      chk("bytewr_lit", f_rdata, 24'hA534A5);
      idle_inputs();

      // Same-cycle write and fetch: read-first
      p_ce = 1'b1; p_we = 1'b1; p_be = 3'b111; p_addr = 4'd7; p_wdata = 24'hFFFFFF;
      f_req = 1'b1; f_addr = 4'd7;
      cyc("coll_wr");
      chk("coll_old_lit", f_rdata, 24'hA5A5A5);
      p_ce = 1'b0;
      cyc("coll_next");
      chk("coll_new_lit", f_rdata, 24'hFFFFFF);

      // Same-cycle fetch and program read
      p_ce = 1'b1; p_we = 1'b0; p_addr = 4'd7;
      cyc("dual_rd");
      chk("dual_rd_eq", f_rdata, p_rdata);
      idle_inputs();
      cyc("hold");

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         f_req   = 1'($urandom);
         f_addr  = 4'($urandom_range(0, 15));
         p_ce    = 1'($urandom);
         p_we    = 1'($urandom);
         p_be    = 3'($urandom);
         p_addr  = 4'($urandom_range(0, 15));
         p_wdata = 24'($urandom);
         cyc("rand");
      end
      idle_inputs();
      tick();

      // Requests held during a sweep, with init_req retriggered mid-sweep
      init_req = 1'b1;
      tick();
      init_req = 1'b0;
      chk("init_busy", busy, 1'b1);
      f_req = 1'b1; p_ce = 1'b1; p_be = 3'b111;
      n = 0; pulses = 0;
      while (busy === 1'b1 && n < 64) begin
         f_addr = 4'($urandom_range(0, 15));
         p_addr = 4'($urandom_range(0, 15));
         p_we = 1'($urandom);
         p_wdata = 24'($urandom);
         init_req = (n == 5);
         tick();
         n++;
         if (f_valid === 1'b1 || p_rvalid === 1'b1) pulses++;
      end
      idle_inputs();
      chk("busy_sweep_len", n, 16);
      chk("busy_no_pulses", pulses, 0);
      chk("busy_frdata_hold", f_rdata, exp_f);
      chk("busy_prdata_hold", p_rdata, exp_p);
      fill_model();
      fetch_all("post_busy_fetch");

      // Reset in the middle of a sweep
      for (int a = 10; a < DEPTH; a++) begin
         p_ce = 1'b1; p_we = 1'b1; p_be = 3'b111; p_addr = 4'(a); p_wdata = 24'($urandom);
         cyc("pre_abort_wr");
      end
      idle_inputs();
      init_req = 1'b1;
      tick();
      init_req = 1'b0;
      repeat (9) tick();
      rstn = 1'b0;
      #1;
      chk("abort_busy", busy, 1'b1);
      chk("abort_frdata", f_rdata, 24'h0);
      tick();
      rstn = 1'b1;
      wait_sweep("abort_sweep_len");
      fill_model();
      exp_f = '0; exp_p = '0;
      fetch_all("abort_fetch");

`ifdef PIC24PROGMEM_PARITY_EN
      u_dut.u_bank.r_mem[3][0] = ~u_dut.u_bank.r_mem[3][0];
      f_req = 1'b1; f_addr = 4'd3;
      tick();
      chk("perr_valid", f_valid, 1'b1);
      chk("perr_bad", f_perr, 1'b1);
      f_addr = 4'd4;
      tick();
      chk("perr_good", f_perr, 1'b0);
      idle_inputs();
      tick();
      chk("perr_idle", f_perr, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
